// File: rtl/dmem_write_buffer_if.sv
// Signal bundle joining the processor data port, the posted-write buffer and DATA_MEMORY.
// The master side is the processor/RAM environment; the slave side is the buffer itself.
interface dmem_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic          cpu_re;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_dout,
    input  cpu_rdata, cpu_stall, mem_addr, mem_din, mem_we, count, empty, full
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_dout,
    output cpu_rdata, cpu_stall, mem_addr, mem_din, mem_we, count, empty, full
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer: stores queue in a small FIFO and drain to RAM whenever no load
// needs the port; loads that hit a pending store are forwarded from the buffer.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input logic                clk,
  input logic                rst,
  dmem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          hit_q, hit_d;
  logic [DW-1:0] fwd_q, fwd_d;

  logic [AW-1:0] reqAddr;
  logic          isEmpty;
  logic          isFull;
  logic          drain;
  logic          match;
  logic [PW-1:0] matchIdx;
  logic [PW-1:0] offset;
  logic          enqueue;
  logic          coalesce;
  logic          unusedAddrBits;

  assign unusedAddrBits = ^bus.cpu_addr[31:AW];

  // The head is excluded from matching while it drains, so a store to the same
  // address lands in a fresh entry instead of being lost with the popped one.
  always_comb begin
    reqAddr  = bus.cpu_addr[AW-1:0];
    isEmpty  = (count_q == '0);
    isFull   = (count_q == CW'(DEPTH));
    drain    = !isEmpty && !bus.cpu_re;
    match    = 1'b0;
    matchIdx = '0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head_q;
      if (({1'b0, offset} < count_q) && !(drain && offset == '0) &&
          (addr_q[i] == reqAddr)) begin
        match    = 1'b1;
        matchIdx = PW'(i);
      end
    end

    enqueue  = bus.cpu_we && !match && (!isFull || drain);
    coalesce = bus.cpu_we && match;

    head_d  = drain   ? head_q + PW'(1) : head_q;
    tail_d  = enqueue ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enqueue) - CW'(drain);
    hit_d   = bus.cpu_re ? match : hit_q;
    fwd_d   = bus.cpu_re ? (match ? data_q[matchIdx] : '0) : fwd_q;
  end

  assign bus.mem_we    = drain;
  assign bus.mem_addr  = bus.cpu_re ? reqAddr : addr_q[head_q];
  assign bus.mem_din   = data_q[head_q];
  assign bus.cpu_stall = bus.cpu_we && isFull && !match && !drain;
  assign bus.cpu_rdata = hit_q ? fwd_q : bus.mem_dout;
  assign bus.count     = count_q;
  assign bus.empty     = isEmpty;
  assign bus.full      = isFull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
      fwd_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      fwd_q   <= fwd_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      addr_q[tail_q] <= reqAddr;
      data_q[tail_q] <= bus.cpu_wdata;
    end
    if (coalesce) begin
      data_q[matchIdx] <= bus.cpu_wdata;
    end
  end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer: a queue model of pending stores predicts
// RAM writes, stalls and load data; a behavioural RAM stands in for DATA_MEMORY.
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 9;
  localparam int DW    = 32;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } entry_t;

  logic clk;
  logic rst;

  dmem_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();

  dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          wr20  = 0;
  entry_t      model[$];
  logic [31:0] loadQ[$];
  logic [31:0] shadow[int];
  logic [31:0] ram[512];
  bit          ramLoaded;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] patternOf(input logic [8:0] a);
    return (a == 9'h040) ? 32'h0 : (32'h5A5A0000 | {23'h0, a});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Synchronous single-port RAM with one cycle of read latency, preloaded once.
  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 512; i++) ram[i] <= patternOf(9'(i));
      ramLoaded <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_din;
    end
    bus.mem_dout <= ram[bus.mem_addr];
  end

  // Mid-cycle scoreboard: checks this cycle's outputs, then advances the model
  // across the coming edge exactly as the buffer should.
  always @(negedge clk) begin
    int     mi;
    bit     drn;
    bit     stExp;
    int     key;
    entry_t e;
    if (rst) begin
      model.delete();
      loadQ.delete();
    end else begin
      if (bus.mem_we && bus.mem_addr == 9'h020) wr20++;
      if (loadQ.size() > 0) checkOutput("rdata", bus.cpu_rdata, loadQ.pop_front());
      drn = (model.size() != 0) && !bus.cpu_re;
      checkOutput("count", 32'(bus.count), 32'(model.size()));
      checkOutput("empty", 32'(bus.empty), 32'(model.size() == 0));
      checkOutput("full", 32'(bus.full), 32'(model.size() == DEPTH));
      checkOutput("mem_we", 32'(bus.mem_we), 32'(drn));
      if (drn) begin
        checkOutput("wr_addr", 32'(bus.mem_addr), 32'(model[0].addr));
        checkOutput("wr_data", bus.mem_din, model[0].data);
      end
      if (bus.cpu_re) checkOutput("rd_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr[8:0]));
      mi = -1;
      for (int i = (drn ? 1 : 0); i < int'(model.size()); i++)
        if (model[i].addr == bus.cpu_addr[8:0]) mi = i;
      key = int'(bus.cpu_addr[8:0]);
      if (bus.cpu_re)
        loadQ.push_back(mi >= 0 ? model[mi].data :
                        (shadow.exists(key) ? shadow[key] : patternOf(bus.cpu_addr[8:0])));
      stExp = bus.cpu_we && (model.size() == DEPTH) && (mi < 0) && !drn;
      checkOutput("stall", 32'(bus.cpu_stall), 32'(stExp));
      if (bus.cpu_we && mi >= 0) model[mi].data = bus.cpu_wdata;
      if (drn) begin
        shadow[int'(model[0].addr)] = model[0].data;
        void'(model.pop_front());
      end
      if (bus.cpu_we && mi < 0 && !stExp) begin
        e.addr = bus.cpu_addr[8:0];
        e.data = bus.cpu_wdata;
        model.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic re,
                               input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    @(negedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    while (bus.empty !== 1'b1 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      n++;
    end
    checkOutput("drain_done", 32'(bus.empty), 32'h1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rst_count", 32'(bus.count), 32'h0);
    checkOutput("rst_empty", 32'(bus.empty), 32'h1);
    checkOutput("rst_full", 32'(bus.full), 32'h0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'h0);
    checkOutput("rst_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("rst_rdata", bus.cpu_rdata, bus.mem_dout);

    // Single store drains on the following cycle.
    applyStimulus(1'b1, 1'b0, 32'h010, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t1_count", 32'(bus.count), 32'h1);
    checkOutput("t1_mem_we", 32'(bus.mem_we), 32'h1);
    checkOutput("t1_mem_addr", 32'(bus.mem_addr), 32'h010);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t1_empty", 32'(bus.empty), 32'h1);
    checkOutput("t1_ram", ram[9'h010], 32'hDEADBEEF);

    // Fill while loads hold the port, stall, then release and drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'(i * 4), 32'h1000 + 32'(i));
    applyStimulus(1'b1, 1'b1, 32'h01C, 32'h00001C1C);
    checkOutput("t2_full", 32'(bus.full), 32'h1);
    checkOutput("t2_stall", 32'(bus.cpu_stall), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h01C, 32'h00001C1C);
    checkOutput("t2_release_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("t2_first_addr", 32'(bus.mem_addr), 32'h000);
    waitDrain();
    checkOutput("t2_ram_00c", ram[9'h00C], 32'h00001003);
    checkOutput("t2_ram_01c", ram[9'h01C], 32'h00001C1C);

    // Coalescing two stores to one address.
    wr20 = 0;
    applyStimulus(1'b1, 1'b1, 32'h020, 32'h11111111);
    applyStimulus(1'b1, 1'b1, 32'h020, 32'h22222222);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h0);
    checkOutput("t3_count", 32'(bus.count), 32'h1);
    waitDrain();
    checkOutput("t3_ram", ram[9'h020], 32'h22222222);
    checkOutput("t3_pulses", 32'(wr20), 32'h1);

    // Forwarding a pending store versus reading RAM.
    applyStimulus(1'b1, 1'b1, 32'h040, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 32'h040, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h044, 32'h0);
    checkOutput("t4_fwd", bus.cpu_rdata, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h0);
    checkOutput("t4_ram", bus.cpu_rdata, patternOf(9'h044));
    waitDrain();

    // Full buffer accepts a new store on a drain cycle.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'h080 + 32'(i * 4), 32'h8000 + 32'(i));
    applyStimulus(1'b1, 1'b0, 32'h090, 32'h00009090);
    checkOutput("t5_stall", 32'(bus.cpu_stall), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t5_count", 32'(bus.count), 32'h4);
    waitDrain();

    // Asynchronous reset discards pending entries.
    applyStimulus(1'b1, 1'b1, 32'h060, 32'hAAAA0060);
    applyStimulus(1'b1, 1'b1, 32'h064, 32'hAAAA0064);
    applyStimulus(1'b1, 1'b1, 32'h068, 32'hAAAA0068);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h0);
    checkOutput("t6_count", 32'(bus.count), 32'h3);
    bus.cpu_re = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t6_empty", 32'(bus.empty), 32'h1);
    checkOutput("t6_mem_we", 32'(bus.mem_we), 32'h0);
    checkOutput("t6_count0", 32'(bus.count), 32'h0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t6_ram_060", ram[9'h060], patternOf(9'h060));
    checkOutput("t6_ram_064", ram[9'h064], patternOf(9'h064));
    checkOutput("t6_ram_068", ram[9'h068], patternOf(9'h068));
    checkOutput("t6_rdata", bus.cpu_rdata, bus.mem_dout);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
